// File: rtl/seg_number_display_if.sv
// Load/handshake bundle between a number source and seg_number_display.
// The master drives the value and control strobes; the display returns busy/done.
interface seg_number_display_if #(
  parameter int unsigned WIDTH = 20
);
  logic [WIDTH-1:0] value;
  logic             load;
  logic             dec_mode;
  logic             blank_lz;
  logic             blink;
  logic             busy;
  logic             done;

  modport master (
    output value, load, dec_mode, blank_lz, blink,
    input  busy, done
  );

  modport slave (
    input  value, load, dec_mode, blank_lz, blink,
    output busy, done
  );
endinterface

// File: rtl/seg_number_display.sv
// Registered 7-segment driver for HEX0..HEX5: hex or double-dabble decimal display with
// leading-zero blanking and overflow dashes. Optional blinking is enabled by defining SEG_BLINK_EN.
module seg_number_display #(
  parameter int unsigned NUM_DIGITS        = 6,
  parameter int unsigned WIDTH             = 20,
  parameter int unsigned BLINK_HALF_PERIOD = 25000000
) (
  input  logic                clk,
  input  logic                rst,
  seg_number_display_if.slave bus,
  output logic [6:0]          HEX0,
  output logic [6:0]          HEX1,
  output logic [6:0]          HEX2,
  output logic [6:0]          HEX3,
  output logic [6:0]          HEX4,
  output logic [6:0]          HEX5
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [6:0]  SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;

  state_t             state, state_nxt;
  logic               busy;
  logic [31:0]        digits;
  logic [31:0]        adj;
  logic [WIDTH-1:0]   shift;
  logic [CNT_W-1:0]   cnt;
  logic               blz_q;
  logic               done_q;
  logic [5:0][6:0]    hex_q;
  logic [5:0][6:0]    hex_nxt;
  logic               ovf;
  logic               nz;
  logic               off;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (bus.load) state_nxt = bus.dec_mode ? CONV : OUT;
      CONV: begin
        busy = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // add-3 correction applied to every BCD digit before each shift
  always_comb begin
    adj = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      adj[4*i +: 4] = (digits[4*i +: 4] >= 4'd5) ? digits[4*i +: 4] + 4'd3 : digits[4*i +: 4];
    end
  end

  // The same digit register holds hex nibbles or BCD, so overflow and blanking share one rule.
  always_comb begin
    ovf = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i >= NUM_DIGITS && digits[4*i +: 4] != 4'd0) ovf = 1'b1;
    end
    nz      = 1'b0;
    hex_nxt = '1;
    for (int unsigned k = 0; k < 6; k++) begin
      int unsigned idx;
      idx = 5 - k;
      if (idx < NUM_DIGITS) begin
        nz = nz | (digits[4*idx +: 4] != 4'd0);
        if (ovf)                            hex_nxt[idx] = SEG_DASH;
        else if (blz_q && !nz && idx != 0)  hex_nxt[idx] = SEG_BLANK;
        else                                hex_nxt[idx] = glyph(digits[4*idx +: 4]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits <= '0;
      shift  <= '0;
      cnt    <= '0;
      blz_q  <= 1'b0;
      done_q <= 1'b0;
      hex_q  <= '1;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.load) begin
          blz_q <= bus.blank_lz;
          cnt   <= '0;
          if (bus.dec_mode) begin
            shift  <= bus.value;
            digits <= '0;
          end else begin
            digits <= 32'(bus.value);
          end
        end
        CONV: begin
          digits <= {adj[30:0], shift[WIDTH-1]};
          shift  <= shift << 1;
          cnt    <= cnt + 1'b1;
        end
        OUT: begin
          hex_q  <= hex_nxt;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SEG_BLINK_EN
  localparam int unsigned BW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
  logic [BW-1:0] blink_cnt;
  logic          phase_off;

  always_ff @(posedge clk) begin
    if (rst || !bus.blink) begin
      blink_cnt <= '0;
      phase_off <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_HALF_PERIOD - 1)) begin
      blink_cnt <= '0;
      phase_off <= ~phase_off;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign off = phase_off;
`else
  logic unused_blink;
  assign unused_blink = ^{bus.blink, BLINK_HALF_PERIOD};
  assign off = 1'b0;
`endif

  assign bus.busy = busy;
  assign bus.done = done_q;

  // unused digits are already blank, so the off phase can simply blank everything
  assign HEX0 = off ? SEG_BLANK : hex_q[0];
  assign HEX1 = off ? SEG_BLANK : hex_q[1];
  assign HEX2 = off ? SEG_BLANK : hex_q[2];
  assign HEX3 = off ? SEG_BLANK : hex_q[3];
  assign HEX4 = off ? SEG_BLANK : hex_q[4];
  assign HEX5 = off ? SEG_BLANK : hex_q[5];

endmodule

// File: tb/tb_seg_number_display.sv
// Self-checking bench for seg_number_display: a 6-digit and a 3-digit instance checked
// against an arithmetic model of the displayed glyphs, latency, busy and done.
module tb_seg_number_display;

  localparam int unsigned W = 20;
  localparam logic [6:0] GL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [6:0]  BLANK   = 7'b1111111;
  localparam logic [6:0]  DASH    = 7'b0111111;
  localparam logic [41:0] ALLBLNK = '1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_number_display_if #(.WIDTH(W)) b6();
  seg_number_display_if #(.WIDTH(W)) b3();
  logic [5:0][6:0] h6, h3;

  seg_number_display #(.NUM_DIGITS(6), .WIDTH(W), .BLINK_HALF_PERIOD(4)) u6 (
    .clk(clk), .rst(rst), .bus(b6),
    .HEX0(h6[0]), .HEX1(h6[1]), .HEX2(h6[2]), .HEX3(h6[3]), .HEX4(h6[4]), .HEX5(h6[5]));

  seg_number_display #(.NUM_DIGITS(3), .WIDTH(W), .BLINK_HALF_PERIOD(4)) u3 (
    .clk(clk), .rst(rst), .bus(b3),
    .HEX0(h3[0]), .HEX1(h3[1]), .HEX2(h3[2]), .HEX3(h3[3]), .HEX4(h3[4]), .HEX5(h3[5]));

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected HEX5..HEX0 from the displayed number's digits in the chosen base.
  function automatic logic [41:0] model(input int unsigned v, input bit dec, input bit blz,
                                        input int unsigned nd);
    longint unsigned base, lim, p;
    logic [41:0] r;
    bit ovf;
    int unsigned d;
    base = dec ? 10 : 16;
    lim  = 1;
    for (int unsigned i = 0; i < nd; i++) lim = lim * base;
    ovf = longint'(v) >= lim;
    p   = 1;
    r   = '1;
    for (int unsigned i = 0; i < 6; i++) begin
      d = int'((longint'(v) / p) % base);
      if (i >= nd)                          r[7*i +: 7] = BLANK;
      else if (ovf)                         r[7*i +: 7] = DASH;
      else if (blz && i > 0 && longint'(v) < p) r[7*i +: 7] = BLANK;
      else                                  r[7*i +: 7] = GL[d];
      p = p * base;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input int unsigned v, input bit dec, input bit blz, input bit ld);
    logic [31:0] vv;
    vv = v;
    if (sel == 6) begin
      b6.value = vv[W-1:0]; b6.dec_mode = dec; b6.blank_lz = blz; b6.load = ld;
    end else begin
      b3.value = vv[W-1:0]; b3.dec_mode = dec; b3.blank_lz = blz; b3.load = ld;
    end
  endtask

  function automatic bit rd_done(input int sel);
    return (sel == 6) ? b6.done : b3.done;
  endfunction
  function automatic bit rd_busy(input int sel);
    return (sel == 6) ? b6.busy : b3.busy;
  endfunction
  function automatic logic [41:0] rd_hex(input int sel);
    return (sel == 6) ? h6 : h3;
  endfunction

  // One load, then wait (bounded) for done; cycle 0 is the cycle load is presented.
  task automatic convert(input int sel, input int unsigned v, input bit dec, input bit blz, input string tag);
    int unsigned cyc, bcount, nd;
    bit got;
    nd = (sel == 6) ? 6 : 3;
    bcount = 0;
    got = 0;
    drive(sel, v, dec, blz, 1'b1);
    step();
    drive(sel, v, dec, blz, 1'b0);
    cyc = 1;
    while (cyc < 100) begin
      if (rd_done(sel)) begin
        got = 1;
        break;
      end
      if (rd_busy(sel)) bcount++;
      step();
      cyc++;
    end
    check({tag, "_done"}, 64'(got), 64'd1);
    check({tag, "_lat"}, 64'(cyc), dec ? 64'(W + 2) : 64'd2);
    check({tag, "_busycyc"}, 64'(bcount), dec ? 64'(W + 1) : 64'd1);
    check({tag, "_busy_at_done"}, 64'(rd_busy(sel)), 64'd0);
    check({tag, "_hex"}, 64'(rd_hex(sel)), 64'(model(v, dec, blz, nd)));
    step();
    check({tag, "_done_pulse"}, 64'(rd_done(sel)), 64'd0);
    check({tag, "_hex_hold"}, 64'(rd_hex(sel)), 64'(model(v, dec, blz, nd)));
  endtask

  initial begin : main
    int unsigned vals[23];
    int unsigned done_cyc[$];
    logic [41:0] done_hex[$];
    int unsigned bcount, ndone;
    int unsigned v;
    bit dec, blz;

    b6.blink = 1'b0;
    b3.blink = 1'b0;
    rst = 1'b1;
    drive(6, 5, 1'b0, 1'b0, 1'b1);
    drive(3, 5, 1'b0, 1'b0, 1'b1);
    step();
    step();
    check("rst_hex6", 64'(h6), 64'(ALLBLNK));
    check("rst_hex3", 64'(h3), 64'(ALLBLNK));
    check("rst_busy", 64'({b6.busy, b3.busy}), 64'd0);
    check("rst_done", 64'({b6.done, b3.done}), 64'd0);
    rst = 1'b0;
    drive(6, 5, 1'b0, 1'b0, 1'b0);
    drive(3, 5, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check("post_rst_busy", 64'({b6.busy, b3.busy}), 64'd0);
    check("post_rst_hex6", 64'(h6), 64'(ALLBLNK));

    convert(6, 12345, 1'b1, 1'b1, "dec12345");
    convert(6, 0, 1'b1, 1'b1, "dec0");
    convert(6, 32'hABCDE, 1'b0, 1'b0, "hexABCDE");
    convert(6, 1048575, 1'b1, 1'b0, "dec_ovf6");
    convert(3, 1000, 1'b1, 1'b1, "dec1000_nd3");
    convert(3, 999, 1'b1, 1'b0, "dec999_nd3");
    convert(3, 32'h1234, 1'b0, 1'b0, "hex_ovf_nd3");
    convert(3, 32'hABC, 1'b0, 1'b1, "hexABC_nd3");
    convert(3, 7, 1'b0, 1'b1, "hex7_nd3");

    for (int i = 0; i < 24; i++) begin
      v   = ($urandom() & 32'hFFFFF) >> $urandom_range(0, 19);
      dec = 1'($urandom_range(0, 1));
      blz = 1'($urandom_range(0, 1));
      convert((i % 2 == 0) ? 6 : 3, v, dec, blz, "rand");
    end

    // load held high through a whole decimal conversion: only IDLE-cycle loads count
    bcount = 0;
    for (int unsigned c = 0; c < 60; c++) begin
      if (c <= 22) begin
        vals[c] = $urandom() & 32'hFFFFF;
        drive(6, vals[c], 1'b1, 1'b1, 1'b1);
      end else begin
        drive(6, 0, 1'b1, 1'b1, 1'b0);
      end
      if (b6.done) begin
        done_cyc.push_back(c);
        done_hex.push_back(h6);
      end
      if (b6.busy) bcount++;
      step();
    end
    check("hold_ndone", 64'(done_cyc.size()), 64'd2);
    check("hold_busycyc", 64'(bcount), 64'(2 * (W + 1)));
    if (done_cyc.size() == 2) begin
      check("hold_done1_cyc", 64'(done_cyc[0]), 64'(W + 2));
      check("hold_done2_cyc", 64'(done_cyc[1]), 64'(2 * (W + 2)));
      check("hold_hex1", 64'(done_hex[0]), 64'(model(vals[0], 1'b1, 1'b1, 6)));
      check("hold_hex2", 64'(done_hex[1]), 64'(model(vals[22], 1'b1, 1'b1, 6)));
    end

    // reset during CONV aborts without a done pulse
    drive(6, 777, 1'b1, 1'b0, 1'b1);
    step();
    drive(6, 777, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c < 5; c++) step();
    check("abort_busy_before", 64'(b6.busy), 64'd1);
    rst = 1'b1;
    step();
    check("abort_busy", 64'(b6.busy), 64'd0);
    check("abort_hex", 64'(h6), 64'(ALLBLNK));
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      if (b6.done) ndone++;
      step();
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    check("abort_hex_after", 64'(h6), 64'(ALLBLNK));

    convert(6, 7, 1'b0, 1'b1, "blink_setup");
    b6.blink = 1'b1;
    for (int unsigned k = 0; k < 14; k++) begin
`ifdef SEG_BLINK_EN
      check("blink_hex0", 64'(h6[0]), 64'(((k / 4) % 2 == 0) ? GL[7] : BLANK));
`else
      check("blink_ignored_hex0", 64'(h6[0]), 64'(GL[7]));
`endif
      check("blink_hex5", 64'(h6[5]), 64'(BLANK));
      step();
    end
    b6.blink = 1'b0;
    step();
    for (int k = 0; k < 8; k++) begin
      check("blink_off_hex", 64'(h6), 64'(model(7, 1'b0, 1'b1, 6)));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
